// File: rtl/bit_enumerator_if.sv
//==============================================================================
// bit_enumerator_if : job-in / beat-out handshake bundle for bit_enumerator
// Revision 1.0
//==============================================================================
`default_nettype none

interface bit_enumerator_if #(
    parameter int WIDTH = 64
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             in_msb_first;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bit;
    logic [IW-1:0]    out_index;
    logic [CW-1:0]    out_seq;
    logic             out_last;
    logic             out_empty;

    // master: job producer and beat consumer
    modport master (
        output in_valid, in_mask, in_msb_first, abort, out_ready,
        input  in_ready, out_valid, out_bit, out_index, out_seq, out_last, out_empty
    );

    modport slave (
        input  in_valid, in_mask, in_msb_first, abort, out_ready,
        output in_ready, out_valid, out_bit, out_index, out_seq, out_last, out_empty
    );
endinterface

`default_nettype wire

// File: rtl/bit_enumerator.sv
//==============================================================================
// bit_enumerator : emits one isolated set bit of a mask per beat, MSB- or LSB-first
// Revision 1.0
//==============================================================================
`default_nettype none

module bit_enumerator #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_enumerator_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_EMPTY = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem;
    logic             r_msb_first;
    logic [CW-1:0]    r_seq;

    logic [WIDTH-1:0] w_lvl [1:IW];
    logic [IW-1:0]    w_msb_idx;
    logic [WIDTH-1:0] w_msb_bit;
    logic [WIDTH-1:0] w_lsb_bit;
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_rem_next;
    logic [IW-1:0]    w_idx;
    logic             w_valid;
    logic             w_last;
    logic             w_beat;
    logic             w_ready;
    logic             w_accept;

    // Halving tree: at level k the live window is 2^(k+1) bits wide; pick the
    // upper half if it holds any set bit, which also sets index bit k.
    assign w_lvl[IW] = r_rem;

    for (genvar k = 0; k < IW; k++) begin : g_msb_tree
        localparam int HALF = 1 << k;
        logic [WIDTH-1:0] w_hi;
        assign w_hi         = w_lvl[k+1] >> HALF;
        assign w_msb_idx[k] = |w_hi;
        if (k > 0) begin : g_next
            assign w_lvl[k] = w_msb_idx[k] ? w_hi : w_lvl[k+1];
        end
    end

    assign w_msb_bit  = (r_rem != '0) ? ({{(WIDTH-1){1'b0}}, 1'b1} << w_msb_idx) : '0;
    assign w_lsb_bit  = r_rem & (-r_rem);
    assign w_bit      = (r_state == S_RUN) ? (r_msb_first ? w_msb_bit : w_lsb_bit) : '0;
    assign w_rem_next = r_rem & ~w_bit;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_bit[i]) begin
                w_idx = w_idx | IW'(i);
            end
        end
    end

    assign w_valid  = !bus.abort && ((r_state == S_RUN) || (r_state == S_EMPTY));
    assign w_last   = (r_state == S_EMPTY) || ((r_state == S_RUN) && (w_rem_next == '0));
    assign w_beat   = w_valid && bus.out_ready;
    // Accepting on the retiring beat lets the next job load with no idle cycle.
    assign w_ready  = !bus.abort && ((r_state == S_IDLE) || (w_beat && w_last));
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_msb_first <= 1'b0;
            r_seq       <= '0;
        end else if (bus.abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_seq   <= '0;
        end else begin
            if (w_beat) begin
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_rem   <= '0;
                    r_seq   <= '0;
                end else begin
                    r_rem <= w_rem_next;
                    r_seq <= r_seq + CW'(1);
                end
            end
            if (w_accept) begin
                r_rem       <= bus.in_mask;
                r_msb_first <= bus.in_msb_first;
                r_seq       <= '0;
                r_state     <= (bus.in_mask != '0) ? S_RUN : S_EMPTY;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_bit   = w_bit;
    assign bus.out_index = w_idx;
    assign bus.out_seq   = (r_state == S_RUN) ? r_seq : '0;
    assign bus.out_last  = w_last;
    assign bus.out_empty = (r_state == S_EMPTY);

endmodule

`default_nettype wire

// File: tb/tb_bit_enumerator.sv
//==============================================================================
// tb_bit_enumerator : directed and randomized checks of bit_enumerator
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_bit_enumerator;
    localparam int WIDTH = 64;
    localparam int IW    = 6;
    localparam int CW    = 7;
    localparam int OW    = WIDTH + IW + CW + 4;

    typedef logic [OW-1:0] obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_enumerator_if #(.WIDTH(WIDTH)) bus();

    bit_enumerator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // {in_ready, out_valid, out_bit, out_index, out_seq, out_last, out_empty}
    function automatic obs_t observe();
        return {bus.in_ready, bus.out_valid, bus.out_bit, bus.out_index,
                bus.out_seq, bus.out_last, bus.out_empty};
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e[OW-1] = 1'b1;
        return e;
    endfunction

    function automatic obs_t beat_obs(input int idx, input int seq, input bit last,
                                      input bit empty, input bit rdy);
        logic [WIDTH-1:0] b;
        b = '0;
        if (!empty) b[idx] = 1'b1;
        return {rdy, 1'b1, b, IW'(empty ? 0 : idx), CW'(seq), last, empty};
    endfunction

    // Reference ordering: the set-bit positions of the mask, in the requested order.
    function automatic void build_order(input logic [WIDTH-1:0] mask, input bit msb);
        exp_q.delete();
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                if (msb) exp_q.push_front(i);
                else     exp_q.push_back(i);
            end
        end
    endfunction

    task automatic start_job(input logic [WIDTH-1:0] mask, input bit msb, input string name);
        @(posedge clk); #1;
        bus.in_valid     = 1'b1;
        bus.in_mask      = mask;
        bus.in_msb_first = msb;
        bus.out_ready    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b expected 1", name, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // mode 0: ready always, 1: ready 1,0,1,0..., 2: random ready
    task automatic do_job(input logic [WIDTH-1:0] mask, input bit msb, input int mode,
                          input string name);
        int   n, nb, beat, cyc, idx;
        bit   rdy;
        obs_t e;
        build_order(mask, msb);
        n  = exp_q.size();
        nb = (n == 0) ? 1 : n;
        start_job(mask, msb, name);
        beat = 0;
        cyc  = 0;
        while (beat < nb && cyc < 4 * WIDTH) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            @(negedge clk);
            idx = 0;
            if (n != 0) idx = exp_q[beat];
            e = beat_obs(idx, beat, beat == nb - 1, n == 0, rdy && (beat == nb - 1));
            checks++;
            if (observe() !== e) begin
                errors++;
                $display("FAIL %s beat %0d cyc %0d: got %h expected %h", name, beat, cyc, observe(), e);
            end
            if (rdy) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        checks++;
        if (beat != nb) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d expected %0d", name, beat, nb);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (observe() !== idle_obs()) begin
            errors++;
            $display("FAIL %s idle after: got %h expected %h", name, observe(), idle_obs());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (observe() !== idle_obs()) begin
            errors++;
            $display("FAIL reset held: got %h expected %h", observe(), idle_obs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (observe() !== idle_obs()) begin
                errors++;
                $display("FAIL reset released: got %h expected %h", observe(), idle_obs());
            end
        end
    endtask

    task automatic test_directed();
        do_job(64'h8000_0000_0000_0001, 1'b1, 0, "two_msb");
        do_job(64'h8000_0000_0000_0001, 1'b0, 0, "two_lsb");
        do_job(64'h0, 1'b1, 0, "empty");
        do_job(64'h0F, 1'b1, 1, "stall_alt");
        do_job({WIDTH{1'b1}}, 1'b0, 0, "all_ones");
        do_job(64'h1, 1'b1, 2, "single");
    endtask

    task automatic test_back_to_back();
        obs_t e;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_mask = 64'h3; bus.in_msb_first = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept A: in_ready=%b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_mask = 64'h10; bus.in_msb_first = 1'b1;
        @(negedge clk);
        e = beat_obs(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (observe() !== e) begin
            errors++;
            $display("FAIL b2b A0: got %h expected %h", observe(), e);
        end
        @(posedge clk); #1;
        @(negedge clk);
        e = beat_obs(1, 1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (observe() !== e) begin
            errors++;
            $display("FAIL b2b A1: got %h expected %h", observe(), e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        e = beat_obs(4, 0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (observe() !== e) begin
            errors++;
            $display("FAIL b2b B0: got %h expected %h", observe(), e);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (observe() !== idle_obs()) begin
            errors++;
            $display("FAIL b2b idle: got %h expected %h", observe(), idle_obs());
        end
    endtask

    task automatic run_beats(input int count, input bit msb, input string name);
        obs_t e;
        bus.out_ready = 1'b1;
        for (int s = 0; s < count; s++) begin
            @(negedge clk);
            e = beat_obs(msb ? WIDTH - 1 - s : s, s, 1'b0, 1'b0, 1'b0);
            checks++;
            if (observe() !== e) begin
                errors++;
                $display("FAIL %s seq %0d: got %h expected %h", name, s, observe(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        start_job({WIDTH{1'b1}}, 1'b1, "abort");
        run_beats(10, 1'b1, "abort");
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL abort cycle: ready,valid=%b expected 00", {bus.in_ready, bus.out_valid});
        end
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (observe() !== idle_obs()) begin
            errors++;
            $display("FAIL abort idle: got %h expected %h", observe(), idle_obs());
        end
        // abort while idle only masks in_ready for that cycle
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL abort idle cycle: ready,valid=%b expected 00", {bus.in_ready, bus.out_valid});
        end
        @(posedge clk); #1;
        bus.abort = 1'b0;
        do_job(64'h0000_0100_0000_0420, 1'b0, 0, "after_abort");
    endtask

    task automatic test_reset_mid_job();
        obs_t e;
        start_job({WIDTH{1'b1}}, 1'b0, "rst_mid");
        run_beats(5, 1'b0, "rst_mid");
        #1;
        e = beat_obs(5, 5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (observe() !== e) begin
            errors++;
            $display("FAIL rst_mid seq5: got %h expected %h", observe(), e);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== idle_obs()) begin
            errors++;
            $display("FAIL rst_mid immediate: got %h expected %h", observe(), idle_obs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (observe() !== idle_obs()) begin
                errors++;
                $display("FAIL rst_mid after release: got %h expected %h", observe(), idle_obs());
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m;
        int sel;
        for (int j = 0; j < 25; j++) begin
            sel = $urandom_range(0, 3);
            m = {$urandom(), $urandom()};
            case (sel)
                0: ;
                1: m = m & {$urandom(), $urandom()} & {$urandom(), $urandom()};
                2: m = '0;
                default: begin
                    m = '0;
                    m[$urandom_range(0, WIDTH - 1)] = 1'b1;
                end
            endcase
            do_job(m, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_mask      = '0;
        bus.in_msb_first = 1'b0;
        bus.abort        = 1'b0;
        bus.out_ready    = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
